tnn_seq_ctrl: RTL and testbench



---
 rtl/tnn_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_tnn_seq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tnn_seq_ctrl.sv
// Time-multiplexed ternary-neuron classifier sequencer: one shared add/compare datapath, one feature per cycle.
// Optional macro TNN_CTRL_HIDDEN_OUT_EN exposes the hidden-bit register as hidden_o.
module tnn_seq_ctrl #(
    parameter int NEURONS  = 4,
    parameter int FEATURES = 7,
    parameter int FW       = 2,
    parameter int VOTE_TH  = 2,
    localparam int NW      = NEURONS * FEATURES,
    localparam int AW      = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FEATURES*FW-1:0] in_feat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   class_o,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [1:0]             cfg_wdata,
    output logic                   cfg_err,
`ifdef TNN_CTRL_HIDDEN_OUT_EN
    output logic [NEURONS-1:0]     hidden_o,
`endif
    output logic                   busy
);
    localparam int ACC_W = $clog2(FEATURES * (2**FW - 1) + 1);
    localparam int FIW   = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam int NIW   = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int PW    = $clog2(NEURONS + 1);

    typedef enum logic [2:0] {IDLE, ACCUM, CMP, VOTE, DONE} state_t;
    state_t state, state_nx;

    logic [FEATURES-1:0][FW-1:0] feat_q;
    logic [NW-1:0][1:0]          wts;
    logic [NIW-1:0]              n_idx;
    logic [FIW-1:0]              f_idx;
    logic [ACC_W-1:0]            pos_acc, neg_acc;
    logic [NEURONS-1:0]          hidden;
    logic                        class_q, cfg_err_q;
    logic [AW-1:0]               rd_idx;
    logic [1:0]                  w_cur;
    logic [FW-1:0]               feat_cur;
    logic [PW-1:0]               pop;
    logic                        f_last, n_last, vote, addr_ok;

    assign rd_idx   = AW'(int'(n_idx) * FEATURES + int'(f_idx));
    assign w_cur    = wts[rd_idx];
    assign feat_cur = feat_q[f_idx];
    assign f_last   = (f_idx == FIW'(FEATURES - 1));
    assign n_last   = (n_idx == NIW'(NEURONS - 1));

    always_comb begin
        pop = '0;
        for (int i = 0; i < NEURONS; i++) pop = pop + PW'(hidden[i]);
    end
    assign vote = (int'(pop) >= VOTE_TH);

    generate
        if (NW == 2**AW) begin : g_full
            assign addr_ok = 1'b1;
        end else begin : g_part
            assign addr_ok = (cfg_addr < AW'(NW));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ACCUM;
            end
            ACCUM: begin
                busy = 1'b1;
                if (f_last) state_nx = CMP;
            end
            CMP: begin
                busy     = 1'b1;
                state_nx = n_last ? VOTE : ACCUM;
            end
            VOTE: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q  <= '0;
            n_idx   <= '0;
            f_idx   <= '0;
            pos_acc <= '0;
            neg_acc <= '0;
            hidden  <= '0;
            class_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    feat_q  <= in_feat;
                    n_idx   <= '0;
                    f_idx   <= '0;
                    pos_acc <= '0;
                    neg_acc <= '0;
                    hidden  <= '0;
                end
                ACCUM: begin
                    f_idx <= f_idx + 1'b1;
                    if (w_cur == 2'b01)      pos_acc <= pos_acc + ACC_W'(feat_cur);
                    else if (w_cur == 2'b10) neg_acc <= neg_acc + ACC_W'(feat_cur);
                end
                CMP: begin
                    // strict compare: a tie leaves the hidden bit at 0
                    hidden[n_idx] <= (pos_acc > neg_acc);
                    pos_acc <= '0;
                    neg_acc <= '0;
                    f_idx   <= '0;
                    if (!n_last) n_idx <= n_idx + 1'b1;
                end
                VOTE:    class_q <= vote;
                default: ;
            endcase
        end
    end

    // weights may only change while no sample is being evaluated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wts       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we & busy;
            if (cfg_we && !busy && addr_ok) wts[cfg_addr] <= cfg_wdata;
        end
    end

    assign class_o = class_q;
    assign cfg_err = cfg_err_q;
`ifdef TNN_CTRL_HIDDEN_OUT_EN
    assign hidden_o = hidden;
`endif
endmodule

// File: tb/tb_tnn_seq_ctrl.sv
// Directed bench for tnn_seq_ctrl with a scoreboard of expected {class, hidden} per sample.
module tb_tnn_seq_ctrl;
    localparam int NEURONS = 4, FEATURES = 7, FW = 2, VOTE_TH = 2;
    localparam int NW = NEURONS * FEATURES, AW = $clog2(NW), LAT = 34;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, cfg_we = 1'b0;
    logic [FEATURES*FW-1:0] in_feat = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [1:0] cfg_wdata = '0;
    logic in_ready, out_valid, class_o, cfg_err, busy;
`ifdef TNN_CTRL_HIDDEN_OUT_EN
    logic [NEURONS-1:0] hidden_o;
`endif

    int errs = 0, checks = 0;
    logic [1:0] mw [NW];
    logic [NEURONS:0] sb [$];

    tnn_seq_ctrl #(.NEURONS(NEURONS), .FEATURES(FEATURES), .FW(FW), .VOTE_TH(VOTE_TH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready), .class_o(class_o), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
`ifdef TNN_CTRL_HIDDEN_OUT_EN
        .hidden_o(hidden_o),
`endif
        .busy(busy));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NEURONS:0] model(input logic [FEATURES*FW-1:0] f);
        logic [NEURONS-1:0] h;
        int pos, neg, pc, v;
        h = '0;
        pc = 0;
        for (int n = 0; n < NEURONS; n++) begin
            pos = 0;
            neg = 0;
            for (int k = 0; k < FEATURES; k++) begin
                v = int'(f[k*FW +: FW]);
                if (mw[n*FEATURES+k] == 2'b01)      pos += v;
                else if (mw[n*FEATURES+k] == 2'b10) neg += v;
            end
            h[n] = (pos > neg);
            pc += int'(h[n]);
        end
        return {(pc >= VOTE_TH), h};
    endfunction

    // entered and left at a negedge, block idle
    task automatic wr(input int a, input logic [1:0] d);
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_wdata = d;
        mw[a] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic clear_w();
        for (int i = 0; i < NW; i++) wr(i, 2'b00);
    endtask

    task automatic run_sample(input string tag, input logic [FEATURES*FW-1:0] feat, input int hold,
                              input int err_at, input int err_addr, input logic [1:0] err_data);
        int waited;
        logic [NEURONS:0] exp;
        sb.push_back(model(feat));
        check({tag, " in_ready idle"}, in_ready, 1);
        in_valid = 1'b1;
        in_feat = feat;
        waited = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            waited++;
            if (waited == 1) begin
                check({tag, " busy after accept"}, busy, 1);
                check({tag, " in_ready after accept"}, in_ready, 0);
            end
            if (err_at != 0) begin
                if (waited == err_at) begin
                    cfg_we = 1'b1;
                    cfg_addr = AW'(err_addr);
                    cfg_wdata = err_data;
                end
                if (waited == err_at + 1) begin
                    cfg_we = 1'b0;
                    check({tag, " cfg_err pulse"}, cfg_err, 1);
                end
                if (waited == err_at + 2) check({tag, " cfg_err clear"}, cfg_err, 0);
            end
        end while (!out_valid && waited < 100);
        check({tag, " latency"}, waited, LAT);
        check({tag, " scoreboard nonempty"}, sb.size() > 0, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check({tag, " class_o"}, class_o, exp[NEURONS]);
`ifdef TNN_CTRL_HIDDEN_OUT_EN
        check({tag, " hidden_o"}, hidden_o, exp[NEURONS-1:0]);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, out_valid, 1);
            check({tag, " hold class_o"}, class_o, exp[NEURONS]);
            check({tag, " hold in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, out_valid, 0);
        check({tag, " back to idle"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < NW; i++) mw[i] = 2'b00;
        repeat (2) @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset class_o", class_o, 0);
        check("reset busy", busy, 0);
        check("reset cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sample("zero_w", 14'h2D71, 0, 0, 0, 2'b00);

        for (int n = 0; n < NEURONS; n++)
            for (int k = 0; k < FEATURES; k++)
                wr(n*FEATURES + k, (n < 2) ? 2'b01 : 2'b10);
        run_sample("vote_0011", 14'h3FFF, 0, 0, 0, 2'b00);
        run_sample("vote_zero_feat", 14'h0000, 0, 0, 0, 2'b00);

        clear_w();
        wr(0, 2'b01); wr(1, 2'b10);
        wr(FEATURES, 2'b01); wr(FEATURES + 1, 2'b10);
        run_sample("tie", 14'h000A, 0, 0, 0, 2'b00);
        run_sample("win_bp", 14'h000B, 10, 0, 0, 2'b00);

        run_sample("busy_wr", 14'h000B, 0, 5, 0, 2'b00);
        run_sample("after_busy_wr", 14'h000B, 0, 0, 0, 2'b00);

        check("pre-reset class_o", class_o, 1);
        in_valid = 1'b1;
        in_feat = 14'h000B;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", in_ready, 1);
        check("midrst out_valid", out_valid, 0);
        check("midrst class_o", class_o, 0);
        check("midrst busy", busy, 0);
        check("midrst cfg_err", cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) mw[i] = 2'b00;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst no out_valid", seen, 0);
        run_sample("post_rst", 14'h000B, 0, 0, 0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
